// File: rtl/usb_cdc_btn_encoder.sv
// Debounces eight button inputs against the USB frame counter and queues one
// ASCII byte per committed edge ('A'+n on press, 'a'+n on release) for CDC IN.
module usb_cdc_btn_encoder #(
    parameter int DEBOUNCE_FRAMES = 10,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  btn_i,
    input  logic [10:0] frame_i,
    input  logic        configured_i,
    output logic [7:0]  in_data_o,
    output logic        in_valid_o,
    input  logic        in_ready_i,
    output logic [7:0]  level_o,
    output logic        overflow_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  LAST_COUNT = 4'(DEBOUNCE_FRAMES - 1);

    logic [7:0]  sync1_reg;
    logic [7:0]  sync_reg;
    logic [10:0] frame_q_reg;
    logic        tick;

    logic [7:0]  level_reg;
    logic [7:0]  level_next;
    logic [7:0]  pol_reg;
    logic [7:0]  pol_next;
    logic [7:0]  pend_reg;
    logic [7:0]  pend_next;
    logic        overflow_reg;
    logic        overflow_next;
    logic [3:0]  cnt_reg  [8];
    logic [3:0]  cnt_next [8];
    logic [7:0]  differ;
    logic [7:0]  commit;

    logic [7:0]  mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic [7:0]  grant;
    logic [7:0]  push_data;

    assign tick = (frame_i != frame_q_reg);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chan
            assign differ[gi] = (sync_reg[gi] != level_reg[gi]);
            // Commit replaces the increment that would reach DEBOUNCE_FRAMES.
            assign commit[gi] = differ[gi] & tick & (cnt_reg[gi] == LAST_COUNT);
            assign cnt_next[gi] = !differ[gi] ? 4'd0 :
                                  !tick       ? cnt_reg[gi] :
                                  commit[gi]  ? 4'd0 :
                                                cnt_reg[gi] + 4'd1;
        end
    endgenerate

    assign level_next = level_reg ^ commit;
    assign pol_next   = (pol_reg & ~commit) | (sync_reg & commit);

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign pop   = !empty && in_ready_i;
    assign push  = configured_i && (pend_reg != 8'd0) && (!full || pop);

    always_comb begin
        push_data = 8'h00;
        grant     = 8'h00;
        if (push) begin
            grant = pend_reg & (~pend_reg + 8'd1);
        end
        for (int i = 7; i >= 0; i--) begin
            if (pend_reg[i]) begin
                push_data = pol_reg[i] ? 8'(8'h41 + i) : 8'(8'h61 + i);
            end
        end
    end

    // A commit landing on a bit that is being pushed this cycle is a fresh event, not an overwrite.
    always_comb begin
        pend_next     = 8'h00;
        overflow_next = 1'b0;
        if (configured_i) begin
            pend_next     = (pend_reg & ~grant) | commit;
            overflow_next = |(commit & pend_reg & ~grant);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_reg    <= 8'h00;
            sync_reg     <= 8'h00;
            frame_q_reg  <= 11'd0;
            level_reg    <= 8'h00;
            pol_reg      <= 8'h00;
            pend_reg     <= 8'h00;
            overflow_reg <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt_reg[i] <= 4'd0;
            end
        end else begin
            sync1_reg    <= btn_i;
            sync_reg     <= sync1_reg;
            frame_q_reg  <= frame_i;
            level_reg    <= level_next;
            pol_reg      <= pol_next;
            pend_reg     <= pend_next;
            overflow_reg <= overflow_next;
            for (int i = 0; i < 8; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= 8'h00;
            end
        end else if (!configured_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign in_valid_o = !empty;
    assign in_data_o  = empty ? 8'h00 : mem_reg[rd_ptr_reg];
    assign level_o    = level_reg;
    assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_usb_cdc_btn_encoder.sv
// Directed bench for usb_cdc_btn_encoder: table of debounce steps plus
// hand-written back-pressure, frame-wrap, reset and unconfigure sequences.
module tb_usb_cdc_btn_encoder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  btn_i;
    logic [10:0] frame_i;
    logic        configured_i;
    logic [7:0]  in_data_o;
    logic        in_valid_o;
    logic        in_ready_i;
    logic [7:0]  level_o;
    logic        overflow_o;

    int total = 0;
    int bad = 0;
    int ovf_count = 0;
    logic [7:0] got[$];

    typedef struct {
        string      name;
        logic [7:0] btn;
        int         frames;
        int         nbytes;
        logic [39:0] bytes;
        logic [7:0] level;
    } vec_t;

    vec_t tbl[6];

    usb_cdc_btn_encoder #(.DEBOUNCE_FRAMES(10), .FIFO_DEPTH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .btn_i        (btn_i),
        .frame_i      (frame_i),
        .configured_i (configured_i),
        .in_data_o    (in_data_o),
        .in_valid_o   (in_valid_o),
        .in_ready_i   (in_ready_i),
        .level_o      (level_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_i && in_valid_o && in_ready_i) got.push_back(in_data_o);
        if (!rst_i && overflow_o) ovf_count++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            frame_i = frame_i + 11'd1;
            repeat (40) @(negedge clk);
        end
    endtask

    task automatic run_step(input string name, input logic [7:0] btn, input int frames,
                            input int nb, input logic [39:0] bytes, input logic [7:0] lvl);
        got.delete();
        btn_i = btn;
        advance(frames);
        repeat (10) @(negedge clk);
        check({name, "_count"}, got.size(), nb);
        for (int i = 0; i < nb; i++) begin
            if (i < got.size()) check($sformatf("%s_byte%0d", name, i), int'(got[i]), int'(bytes[8*i +: 8]));
        end
        check({name, "_level"}, int'(level_o), int'(lvl));
    endtask

    initial begin
        tbl[0] = '{"press0",     8'h01, 12, 1, 40'h41,   8'h01};
        tbl[1] = '{"release0",   8'h00, 12, 1, 40'h61,   8'h00};
        tbl[2] = '{"short2",     8'h04,  9, 0, 40'h0,    8'h00};
        tbl[3] = '{"short2_end", 8'h00,  5, 0, 40'h0,    8'h00};
        tbl[4] = '{"press13",    8'h0A, 12, 2, 40'h4442, 8'h0A};
        tbl[5] = '{"release13",  8'h00, 12, 2, 40'h6462, 8'h00};

        rst_i = 1'b1;
        btn_i = 8'h00;
        frame_i = 11'd0;
        configured_i = 1'b1;
        in_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(in_valid_o), 0);
        check("rst_data", int'(in_data_o), 0);
        check("rst_level", int'(level_o), 0);
        check("rst_ovf", int'(overflow_o), 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_step(tbl[v].name, tbl[v].btn, tbl[v].frames, tbl[v].nbytes, tbl[v].bytes, tbl[v].level);
        end

        // Back-pressure: five simultaneous commits, four fit, one waits in pend.
        in_ready_i = 1'b0;
        got.delete();
        btn_i = 8'h1F;
        advance(12);
        repeat (10) @(negedge clk);
        check("bp_valid", int'(in_valid_o), 1);
        check("bp_head", int'(in_data_o), 8'h41);
        repeat (30) @(negedge clk);
        check("bp_head_stable", int'(in_data_o), 8'h41);
        check("bp_none_taken", got.size(), 0);
        check("bp_level", int'(level_o), 8'h1F);
        in_ready_i = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_count", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) check($sformatf("bp_byte%0d", i), int'(got[i]), 8'h41 + i);
        end
        check("bp_empty_valid", int'(in_valid_o), 0);
        check("bp_empty_data", int'(in_data_o), 0);
        check("bp_ovf", ovf_count, 0);
        run_step("bp_release", 8'h00, 12, 5, 40'h6564636261, 8'h00);

        // Frame counter wrap 2047 -> 0 counts as a tick.
        frame_i = 11'd2039;
        repeat (40) @(negedge clk);
        run_step("wrap", 8'h80, 11, 1, 40'h48, 8'h80);
        run_step("wrap_rel", 8'h00, 12, 1, 40'h68, 8'h00);

        // Reset with three bytes queued.
        in_ready_i = 1'b0;
        got.delete();
        btn_i = 8'h07;
        advance(12);
        repeat (10) @(negedge clk);
        check("rstq_valid_before", int'(in_valid_o), 1);
        btn_i = 8'h00;
        rst_i = 1'b1;
        @(negedge clk);
        check("rstq_valid_after", int'(in_valid_o), 0);
        check("rstq_level", int'(level_o), 0);
        rst_i = 1'b0;
        in_ready_i = 1'b1;
        repeat (20) @(negedge clk);
        check("rstq_no_bytes", got.size(), 0);

        // Unconfigure with three bytes queued, then track levels while unconfigured.
        in_ready_i = 1'b0;
        got.delete();
        btn_i = 8'h07;
        advance(12);
        repeat (10) @(negedge clk);
        check("unc_valid_before", int'(in_valid_o), 1);
        configured_i = 1'b0;
        @(negedge clk);
        check("unc_valid_after", int'(in_valid_o), 0);
        in_ready_i = 1'b1;
        run_step("unc_release", 8'h00, 12, 0, 40'h0, 8'h00);
        run_step("unc_press5", 8'h20, 12, 0, 40'h0, 8'h20);
        configured_i = 1'b1;
        repeat (20) @(negedge clk);
        check("reconf_silent", got.size(), 0);
        run_step("reconf_rel5", 8'h00, 12, 1, 40'h66, 8'h00);
        check("final_ovf", ovf_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_cdc_btn_encoder.md
Name: usb_cdc_btn_encoder

Overview:
- Upstream feeder for the USB CDC bulk IN endpoint in the TT USB CDC devices top level.
- Debounces the 8 ui_in lines against the USB frame number, which advances on each SOF.
- Turns each debounced edge into one ASCII byte: press on channel n sends 'A'+n (0x41+n); release sends 'a'+n (0x61+n).
- Queues the bytes and presents them on the CDC IN valid/ready byte interface.

Parameters:
- DEBOUNCE_FRAMES, 10: number of frame-number changes an input must hold a new level before the change is committed. Range 1..15.
- FIFO_DEPTH, 4: output byte queue depth. Power of two, minimum 2.

Ports:
- clk_i  input  1  48 MHz system clock (same clock as the USB CDC core).
- rst_i  input  1  synchronous reset, active high.
- btn_i  input  8  raw asynchronous inputs from ui_in.
- frame_i  input  11  current USB frame number from the CDC core.
- configured_i  input  1  high while the device is configured by the host.
- in_data_o  output  8  ASCII byte at the queue head.
- in_valid_o  output  1  in_data_o is valid.
- in_ready_i  input  1  CDC core accepts the byte when in_valid_o and in_ready_i are both high at a rising edge.
- level_o  output  8  committed (debounced) levels.
- overflow_o  output  1  one-cycle pulse when an uncommitted pending event is overwritten.

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: every register is cleared on the clk_i edge where rst_i=1.
  - Outputs after reset: in_data_o=0x00, in_valid_o=0, level_o=0x00, overflow_o=0.
  - Internal state after reset: queue empty, pending bits clear, counters 0, frame_q=0.
  - Reset mid-transfer discards all queued and pending events.
- Synchroniser: 2-flop synchroniser per bit gives sync[7:0]; debounce logic sees only sync.
- Frame tick: frame_q registers frame_i; tick = (frame_i != frame_q).
  - Any change counts as one tick, including the wrap 2047->0.
  - The first value seen after reset counts as one tick.
- Per-channel debounce (4-bit counter cnt[n]):
  - sync[n]==level[n]: cnt[n] <= 0, with or without a tick.
  - sync[n]!=level[n] and tick: cnt[n] <= cnt[n]+1.
  - If that increment reaches DEBOUNCE_FRAMES, commit instead of storing the count: level[n] <= sync[n], cnt[n] <= 0, pend[n] <= 1, pol[n] <= sync[n] (1 = press).
  - sync[n]!=level[n] without a tick: cnt[n] holds.
  - A glitch back to level[n] before commit clears cnt[n] and produces no event.
- Overwrite: if pend[n] is already set when a new commit occurs on channel n, pol[n] takes the new value and overflow_o pulses for one cycle.
- Arbiter: each cycle in which the queue is not full or a pop is occurring, the lowest-index set pend[n] is pushed and that pend bit is cleared.
  - Byte pushed: pol ? 0x41+n : 0x61+n.
  - One push per cycle.
- Latency: commit edge E; push at E+1; in_valid_o=1 from E+1 when the queue was empty. Latency is 1 cycle.
- Queue: synchronous FIFO, FIFO_DEPTH entries.
  - in_valid_o = !empty; in_data_o = head entry (0x00 when empty).
  - Pop on in_valid_o & in_ready_i.
  - Simultaneous push and pop is allowed when full: occupancy is unchanged and order is preserved.
  - Push is blocked only when full with no pop. The event waits in pend and is never dropped.
- configured_i=0:
  - Queue is flushed, pend is cleared, arbiter is idle, in_valid_o=0.
  - Debounce keeps tracking and level_o keeps updating.
  - Commits while unconfigured generate no event.
  - The rising edge of configured_i emits nothing by itself.
- in_data_o remains stable while in_valid_o=1 and in_ready_i=0.

Test Plan:
- Reset, configured_i=1, btn_i[0]=1, advance frame_i 0..11 (one per ~1000 clocks), in_ready_i=1 -> single handshake with byte 0x41 after the 10th frame change; level_o=0x01.
- Then btn_i[0]=0 and 12 more frame changes -> single byte 0x61; level_o=0x00; no other bytes.
- btn_i[2]=1 held for 9 frame changes, then dropped, then 5 more frames -> no in_valid_o; level_o stays 0x00.
- btn_i[3] and btn_i[1] rise in the same cycle with in_ready_i=1 -> bytes 0x42 then 0x44 on consecutive handshakes.
- Back-pressure with in_ready_i=0: press/release sequence on channels 0-4 producing 5 events -> queue holds 4 with in_data_o stable at the first byte and the 5th held pending. Then in_ready_i=1 -> all 5 bytes delivered in commit order; overflow_o never pulses.
- Frame wrap: frame_i 2040..2047,0,1,2 with btn_i[7]=1 -> 0x48 after the 10th change.
- Mid-operation control:
  - Assert rst_i with 3 bytes queued -> in_valid_o=0 next cycle.
  - Drop configured_i with 3 bytes queued -> in_valid_o=0 next cycle.
  - Press during unconfigured -> level_o updates, no byte.
